// File: rtl/demux_deser.sv
// Symbol deserialiser: packs SYM_W-bit symbols into NUM_SLOTS-symbol words (slot 0 in the MSBs),
// with flush for partial words. Define DEMUX_DESER_OVERLAP_EN to keep accepting symbols while a word is held.
module demux_deser #(
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic                               inClk,
  input  logic                               inReset,
  input  logic [SYM_W-1:0]                   inData,
  input  logic                               inValid,
  output logic                               outInReady,
  input  logic                               inFlush,
  output logic [SYM_W*NUM_SLOTS-1:0]         outData,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     outCount,
  output logic                               outValid,
  input  logic                               inOutReady
);

  localparam int unsigned WORD_W = SYM_W * NUM_SLOTS;
  localparam int unsigned IDX_W  = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_HOLD
`ifdef DEMUX_DESER_OVERLAP_EN
    , S_PEND
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WORD_W-1:0]  r_acc, w_acc_nxt, w_acc_upd;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [WORD_W-1:0]  r_out_data, w_out_data_nxt;
  logic [CNT_W-1:0]   r_out_count, w_out_count_nxt;
  logic               r_out_valid, w_out_valid_nxt;
`ifdef DEMUX_DESER_OVERLAP_EN
  logic [CNT_W-1:0]   r_pend_count, w_pend_count_nxt;
`endif

  logic               w_in_ready, w_accept, w_full, w_flush, w_complete, w_consume;
  logic [CNT_W-1:0]   w_count;
  int unsigned        w_shift;

  // Intake readiness depends on state only (and reset), never on inValid
  always_comb begin
    w_in_ready = 1'b0;
    if (!inReset) begin
      case (r_state)
        S_FILL:  w_in_ready = 1'b1;
`ifdef DEMUX_DESER_OVERLAP_EN
        S_HOLD:  w_in_ready = 1'b1;
`endif
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  // Slots beyond idx are always zero, so an OR inserts the new symbol
  always_comb begin
    w_accept   = inValid && w_in_ready;
    w_full     = w_accept && (r_idx == IDX_W'(NUM_SLOTS - 1));
    w_flush    = inFlush && (w_accept || (r_idx != '0));
    w_complete = w_full || w_flush;
    w_consume  = r_out_valid && inOutReady;
    w_shift    = SYM_W * (NUM_SLOTS - 1 - 32'(r_idx));
    w_acc_upd  = w_accept ? (r_acc | (WORD_W'(inData) << w_shift)) : r_acc;
    w_count    = w_full ? CNT_W'(NUM_SLOTS) : (CNT_W'(r_idx) + CNT_W'(w_accept));
  end

  // Next-state and register updates
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = w_acc_upd;
    w_idx_nxt       = w_accept ? (r_idx + IDX_W'(1)) : r_idx;
    w_out_data_nxt  = r_out_data;
    w_out_count_nxt = r_out_count;
    w_out_valid_nxt = r_out_valid;
`ifdef DEMUX_DESER_OVERLAP_EN
    w_pend_count_nxt = r_pend_count;
`endif
    if (w_complete) begin
      w_acc_nxt = '0;
      w_idx_nxt = '0;
    end

    case (r_state)
      S_FILL: begin
        if (w_complete) begin
          w_out_data_nxt  = w_acc_upd;
          w_out_count_nxt = w_count;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_complete && w_consume) begin
          w_out_data_nxt  = w_acc_upd;
          w_out_count_nxt = w_count;
        end
`ifdef DEMUX_DESER_OVERLAP_EN
        else if (w_complete) begin
          w_acc_nxt        = w_acc_upd;
          w_pend_count_nxt = w_count;
          w_state_nxt      = S_PEND;
        end
`endif
        else if (w_consume) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_FILL;
        end
      end
`ifdef DEMUX_DESER_OVERLAP_EN
      S_PEND: begin
        if (w_consume) begin
          w_out_data_nxt  = r_acc;
          w_out_count_nxt = r_pend_count;
          w_acc_nxt       = '0;
          w_state_nxt     = S_HOLD;
        end
      end
`endif
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      r_state     <= S_FILL;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
`ifdef DEMUX_DESER_OVERLAP_EN
      r_pend_count <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_idx       <= w_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef DEMUX_DESER_OVERLAP_EN
      r_pend_count <= w_pend_count_nxt;
`endif
    end
  end

  assign outInReady = w_in_ready;
  assign outData    = r_out_data;
  assign outCount   = r_out_count;
  assign outValid   = r_out_valid;

endmodule

// File: tb/tb_demux_deser.sv
// Randomised and directed bench for demux_deser against a symbol-queue reference model.
module tb_demux_deser;

  localparam int SYM_W     = 4;
  localparam int NUM_SLOTS = 8;
`ifdef DEMUX_DESER_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic        inClk = 1'b0;
  logic        inReset;
  logic [3:0]  inData;
  logic        inValid, inFlush, inOutReady;
  logic        outInReady, outValid;
  logic [31:0] outData;
  logic [3:0]  outCount;

  logic [1:0]  d2_data;
  logic        d2_valid, d2_ready_o, d2_valid_o;
  logic [7:0]  d2_out;
  logic [2:0]  d2_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 inClk = ~inClk;

  demux_deser #(.SYM_W(SYM_W), .NUM_SLOTS(NUM_SLOTS)) dut (
    .inClk(inClk), .inReset(inReset), .inData(inData), .inValid(inValid),
    .outInReady(outInReady), .inFlush(inFlush), .outData(outData),
    .outCount(outCount), .outValid(outValid), .inOutReady(inOutReady)
  );

  demux_deser #(.SYM_W(2), .NUM_SLOTS(4)) dut2 (
    .inClk(inClk), .inReset(inReset), .inData(d2_data), .inValid(d2_valid),
    .outInReady(d2_ready_o), .inFlush(1'b0), .outData(d2_out),
    .outCount(d2_count), .outValid(d2_valid_o), .inOutReady(1'b1)
  );

  // Reference model: symbols of the open word, output word and a possible pending word
  int          q[$];
  bit          m_valid, m_pend;
  logic [31:0] m_data, m_pend_data;
  int          m_count, m_pend_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_valid || (OV && !m_pend);
  endfunction

  function automatic logic [31:0] pack_word();
    logic [31:0] w = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w = w << SYM_W;
      if (i < q.size()) w = w | 32'(q[i]);
    end
    return w;
  endfunction

  task automatic m_reset();
    q.delete();
    m_valid = 0; m_pend = 0;
    m_data = '0; m_count = 0; m_pend_data = '0; m_pend_count = 0;
  endtask

  task automatic model_step();
    bit acc, cons, comp;
    logic [31:0] w;
    int c;
    acc  = inValid && m_ready();
    cons = m_valid && inOutReady;
    comp = 0; w = '0; c = 0;
    if (acc) q.push_back(int'(inData));
    if (q.size() == NUM_SLOTS || (inFlush && q.size() > 0)) begin
      comp = 1; w = pack_word(); c = q.size(); q.delete();
    end
    if (m_pend) begin
      if (cons) begin m_data = m_pend_data; m_count = m_pend_count; m_pend = 0; end
    end else if (m_valid) begin
      if (comp && cons) begin m_data = w; m_count = c; end
      else if (comp) begin m_pend = 1; m_pend_data = w; m_pend_count = c; end
      else if (cons) m_valid = 0;
    end else if (comp) begin
      m_valid = 1; m_data = w; m_count = c;
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(outValid), 32'(m_valid));
    check_eq("ready", 32'(outInReady), 32'(m_ready()));
    if (m_valid) begin
      check_eq("data", outData, m_data);
      check_eq("count", 32'(outCount), 32'(m_count));
    end
  endtask

  // Called at a falling edge: drive, advance the model one edge, compare at the next falling edge
  task automatic step(input bit v, input logic [3:0] d, input bit f, input bit r);
    inValid = v; inData = d; inFlush = f; inOutReady = r;
    model_step();
    @(negedge inClk);
    check_outputs();
  endtask

  initial begin
    logic [1:0] syms2 [4];
    syms2 = '{2'd3, 2'd0, 2'd1, 2'd2};
    inReset = 1'b1; inValid = 0; inData = '0; inFlush = 0; inOutReady = 0;
    d2_valid = 0; d2_data = '0;
    m_reset();
    repeat (2) @(negedge inClk);
    check_eq("rst_valid", 32'(outValid), 32'd0);
    check_eq("rst_data", outData, 32'd0);
    check_eq("rst_count", 32'(outCount), 32'd0);
    check_eq("rst_ready", 32'(outInReady), 32'd0);
    inReset = 1'b0;
    #1 check_eq("ready_after_rst", 32'(outInReady), 32'd1);

    // Full word, back-to-back
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 1);
    check_eq("full_valid", 32'(outValid), 32'd1);
    check_eq("full_data", outData, 32'h12345678);
    check_eq("full_count", 32'(outCount), 32'd8);
    step(0, 4'd0, 0, 1);
    check_eq("full_one_cycle", 32'(outValid), 32'd0);

    // Partial flush, then flush of an empty word
    step(1, 4'hA, 0, 1); step(1, 4'hB, 0, 1); step(1, 4'hC, 0, 1);
    step(0, 4'd0, 1, 1);
    check_eq("flush_data", outData, 32'hABC00000);
    check_eq("flush_count", 32'(outCount), 32'd3);
    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 1, 1);
    check_eq("flush_empty", 32'(outValid), 32'd0);

    // Backpressure
    for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 4'($urandom), 0, 0);
      check_eq("bp_hold", outData, 32'h01234567);
      if (!OV) check_eq("bp_ready", 32'(outInReady), 32'd0);
    end
    repeat (4) step(0, 4'd0, 0, 1);

`ifdef DEMUX_DESER_OVERLAP_EN
    // Consume on the same edge as the completing accept
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0);
    for (int i = 8; i >= 2; i--) step(1, 4'(i), 0, 0);
    step(1, 4'd1, 0, 1);
    check_eq("ovl_valid", 32'(outValid), 32'd1);
    check_eq("ovl_data", outData, 32'h87654321);
    repeat (2) step(0, 4'd0, 0, 1);
`endif

    // Asynchronous reset between edges with a word held and a partial word open
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'hF, 0, 0);
    #2 inReset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(outValid), 32'd0);
    check_eq("arst_data", outData, 32'd0);
    check_eq("arst_count", 32'(outCount), 32'd0);
    check_eq("arst_ready", 32'(outInReady), 32'd0);
    @(negedge inClk);
    inReset = 1'b0;
    m_reset();
    for (int i = 0; i < 8; i++) step(1, 4'(9 + i), 0, 1);
    check_eq("post_rst_data", outData, 32'h9ABCDEF0);
    check_eq("post_rst_count", 32'(outCount), 32'd8);
    step(0, 4'd0, 0, 1);

    // Randomised traffic
    repeat (3000)
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 6);
    repeat (4) step(0, 4'd0, 0, 1);

    // Narrow configuration: SYM_W=2, NUM_SLOTS=4
    for (int i = 0; i < 4; i++) begin
      d2_valid = 1; d2_data = syms2[i];
      @(negedge inClk);
    end
    d2_valid = 0;
    check_eq("narrow_valid", 32'(d2_valid_o), 32'd1);
    check_eq("narrow_data", 32'(d2_out), 32'hC6);
    check_eq("narrow_count", 32'(d2_count), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
